// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter between N cache clients and one
// physical-memory / L2 port.
//
// A single transaction is in flight at a time. In IDLE the first requester
// at or after the priority pointer is granted; its address, write line and
// op type are latched, and the pmem command is held from state until
// pmem_resp. The read line is registered and a one-cycle cl_resp strobe is
// returned to the granted client only, after which the pointer moves past it.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   cl_read / cl_write   per-client request bits (both set = write)
//   cl_address           flattened client addresses, client i at [i*AW +: AW]
//   cl_wdata             flattened client write lines, same packing
//   cl_resp              one-hot, one-cycle completion strobe
//   cl_rdata             registered read line shared by all clients
//   pmem_read/write      memory command, held while BUSY
//   pmem_address/wdata   latched address / write line
//   pmem_resp/rdata      memory completion and read line
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             cl_read,
  input  logic [NUM_PORTS-1:0]             cl_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cl_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  cl_wdata,
  output logic [NUM_PORTS-1:0]             cl_resp,
  output logic [LINE_WIDTH-1:0]            cl_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic                             pmem_resp,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;

  logic [PW-1:0] ptr, g, gnt_idx, cand;
  logic          gnt_found;
  logic          op_write;

  logic [NUM_PORTS-1:0] req;

  // Packed per-client views of the flattened buses.
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] wdata_a;

  assign req     = cl_read | cl_write;
  assign addr_a  = cl_address;
  assign wdata_a = cl_wdata;

  // Scan from the pointer upward with explicit wrap so that non-power-of-2
  // port counts never select a nonexistent client.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. RESP always returns to IDLE without granting, so the
  // completing client's still-asserted request cannot be picked up again.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = BUSY;
      BUSY:    if (pmem_resp) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    pmem_read  = (state == BUSY) && !op_write;
    pmem_write = (state == BUSY) &&  op_write;
    cl_resp    = '0;
    if (state == RESP) cl_resp[g] = 1'b1;
  end

  // Datapath: grant latch, read-line capture, pointer advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr          <= '0;
      g            <= '0;
      op_write     <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      cl_rdata     <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_found) begin
          g            <= gnt_idx;
          op_write     <= cl_write[gnt_idx];
          pmem_address <= addr_a[gnt_idx];
          if (cl_write[gnt_idx]) pmem_wdata <= wdata_a[gnt_idx];
        end
        BUSY: if (pmem_resp && !op_write) cl_rdata <= pmem_rdata;
        RESP: ptr <= (g == LAST) ? '0 : g + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Two-port instance
  logic [1:0]   c2_read, c2_write, r2_resp;
  logic [31:0]  c2_addr;
  logic [255:0] c2_wdata;
  logic [127:0] r2_rdata, p2_wdata, p2_rdata;
  logic         p2_read, p2_write, p2_resp;
  logic [15:0]  p2_addr;

  // Three-port instance
  logic [2:0]   c3_read, c3_write, r3_resp;
  logic [47:0]  c3_addr;
  logic [383:0] c3_wdata;
  logic [127:0] r3_rdata, p3_wdata, p3_rdata;
  logic         p3_read, p3_write, p3_resp;
  logic [15:0]  p3_addr;

  int checks = 0;
  int errors = 0;
  logic [127:0] last_rd;

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cl_read(c2_read), .cl_write(c2_write), .cl_address(c2_addr), .cl_wdata(c2_wdata),
    .cl_resp(r2_resp), .cl_rdata(r2_rdata),
    .pmem_read(p2_read), .pmem_write(p2_write), .pmem_address(p2_addr),
    .pmem_wdata(p2_wdata), .pmem_resp(p2_resp), .pmem_rdata(p2_rdata)
  );

  mem_arbiter_rr #(.NUM_PORTS(3), .ADDR_WIDTH(16), .LINE_WIDTH(128)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cl_read(c3_read), .cl_write(c3_write), .cl_address(c3_addr), .cl_wdata(c3_wdata),
    .cl_resp(r3_resp), .cl_rdata(r3_rdata),
    .pmem_read(p3_read), .pmem_write(p3_write), .pmem_address(p3_addr),
    .pmem_wdata(p3_wdata), .pmem_resp(p3_resp), .pmem_rdata(p3_rdata)
  );

  // Memory responders: wait (bounded) for a command, keep it for lat cycles,
  // answer on the last one. Returns #1 after the edge that enters RESP.
  task automatic serve2(input int lat, input logic [127:0] rd, output int cmd_cyc, output bit to);
    int w;
    w = 0; cmd_cyc = 0; to = 1'b0;
    while (!(p2_read || p2_write) && w < 20) begin @(posedge clk); #1; w++; end
    if (!(p2_read || p2_write)) begin to = 1'b1; return; end
    for (int i = 0; i < lat; i++) begin
      if (p2_read || p2_write) cmd_cyc++;
      if (i == lat - 1) begin p2_resp = 1'b1; p2_rdata = rd; end
      @(posedge clk); #1;
    end
    p2_resp = 1'b0;
  endtask

  task automatic serve3(input int lat, input logic [127:0] rd, output int cmd_cyc, output bit to);
    int w;
    w = 0; cmd_cyc = 0; to = 1'b0;
    while (!(p3_read || p3_write) && w < 20) begin @(posedge clk); #1; w++; end
    if (!(p3_read || p3_write)) begin to = 1'b1; return; end
    for (int i = 0; i < lat; i++) begin
      if (p3_read || p3_write) cmd_cyc++;
      if (i == lat - 1) begin p3_resp = 1'b1; p3_rdata = rd; end
      @(posedge clk); #1;
    end
    p3_resp = 1'b0;
  endtask

  task automatic test_reset();
    logic [275:0] o2;
    rst_n = 1'b0;
    c2_read = '0; c2_write = '0; c2_addr = '0; c2_wdata = '0; p2_resp = 1'b0; p2_rdata = '0;
    c3_read = '0; c3_write = '0; c3_addr = '0; c3_wdata = '0; p3_resp = 1'b0; p3_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      o2 = {r2_resp, r2_rdata, p2_read, p2_write, p2_addr, p2_wdata};
      checks++;
      if (o2 !== '0) begin errors++; $display("FAIL reset_outputs cycle %0d got %h expected 0", i, o2); end
    end
    checks++;
    if ({r3_resp, p3_read, p3_write, p3_addr} !== '0) begin
      errors++; $display("FAIL reset_outputs_3port got %h expected 0", {r3_resp, p3_read, p3_write, p3_addr});
    end
    // Reset in the middle of a read
    rst_n = 1'b1;
    c2_addr[15:0] = 16'h0111; c2_read = 2'b01;
    @(posedge clk); #1;
    checks++;
    if (p2_read !== 1'b1) begin errors++; $display("FAIL pre_reset_cmd got %b expected 1", p2_read); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({p2_read, r2_resp} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_busy got read=%b resp=%b expected 0/00", p2_read, r2_resp);
    end
    c2_read = 2'b00; rst_n = 1'b1;
    @(posedge clk); #1;
    p2_resp = 1'b1; p2_rdata = '1;
    @(posedge clk); #1;
    p2_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({r2_resp, p2_read, r2_rdata} !== '0) begin
        errors++; $display("FAIL late_pmem_resp cycle %0d got resp=%b read=%b rdata=%h expected all 0", i, r2_resp, p2_read, r2_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_read();
    int cyc; bit to;
    c2_addr[15:0] = 16'h1230; c2_read = 2'b01;
    @(posedge clk); #1;
    checks++;
    if ({p2_read, p2_write, p2_addr} !== {2'b10, 16'h1230}) begin
      errors++; $display("FAIL read_cmd got rd=%b wr=%b addr=%h expected 1/0/1230", p2_read, p2_write, p2_addr);
    end
    serve2(4, {16{8'hA5}}, cyc, to);
    checks++;
    if (to || cyc != 4) begin errors++; $display("FAIL read_cmd_cycles got %0d (timeout=%0d) expected 4", cyc, to); end
    checks++;
    if ({r2_resp, p2_read} !== 3'b010 || r2_rdata !== {16{8'hA5}}) begin
      errors++; $display("FAIL read_resp got resp=%b read=%b rdata=%h expected 01/0/a5..", r2_resp, p2_read, r2_rdata);
    end
    last_rd = {16{8'hA5}};
    c2_read = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (r2_resp !== 2'b00 || r2_rdata !== last_rd) begin
      errors++; $display("FAIL read_resp_one_cycle got resp=%b rdata=%h expected 00/a5..", r2_resp, r2_rdata);
    end
  endtask

  task automatic test_single_write();
    int cyc; bit to;
    c2_addr[31:16] = 16'h4000; c2_wdata[255:128] = {4{32'hDEADBEEF}}; c2_write = 2'b10;
    @(posedge clk); #1;
    checks++;
    if ({p2_read, p2_write, p2_addr} !== {2'b01, 16'h4000} || p2_wdata !== {4{32'hDEADBEEF}}) begin
      errors++; $display("FAIL write_cmd got rd=%b wr=%b addr=%h wdata=%h", p2_read, p2_write, p2_addr, p2_wdata);
    end
    serve2(2, {4{32'h0BADF00D}}, cyc, to);
    checks++;
    if (to || cyc != 2) begin errors++; $display("FAIL write_cmd_cycles got %0d (timeout=%0d) expected 2", cyc, to); end
    checks++;
    if ({r2_resp, p2_write} !== 3'b100 || r2_rdata !== last_rd) begin
      errors++; $display("FAIL write_resp got resp=%b write=%b rdata=%h expected 10/0/unchanged", r2_resp, p2_write, r2_rdata);
    end
    c2_write = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    int e;
    logic [127:0] rd;
    logic [15:0] ea;
    c2_addr = {16'h0B00, 16'h0A00}; c2_read = 2'b11;
    for (int t = 0; t < 4; t++) begin
      e = t % 2;
      ea = (e == 0) ? 16'h0A00 : 16'h0B00;
      rd = {4{32'hC0DE0000 + 32'(t)}};
      serve2(1, rd, cyc, to);
      checks++;
      if (to || r2_resp !== (2'b01 << e) || p2_addr !== ea || r2_rdata !== rd) begin
        errors++; $display("FAIL rr_order txn %0d got resp=%b addr=%h rdata=%h expected resp=%b addr=%h", t, r2_resp, p2_addr, r2_rdata, 2'b01 << e, ea);
      end
      last_rd = rd;
    end
    c2_read = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_rw_and_spurious();
    int cyc; bit to;
    c2_addr[15:0] = 16'h2220; c2_wdata[127:0] = {4{32'h12345678}};
    c2_read = 2'b01; c2_write = 2'b01;
    @(posedge clk); #1;
    checks++;
    if ({p2_read, p2_write} !== 2'b01 || p2_wdata !== {4{32'h12345678}} || p2_addr !== 16'h2220) begin
      errors++; $display("FAIL rw_as_write got rd=%b wr=%b addr=%h wdata=%h", p2_read, p2_write, p2_addr, p2_wdata);
    end
    serve2(1, '1, cyc, to);
    checks++;
    if (to || r2_resp !== 2'b01 || r2_rdata !== last_rd) begin
      errors++; $display("FAIL rw_resp got resp=%b rdata=%h expected 01/unchanged", r2_resp, r2_rdata);
    end
    c2_read = 2'b00; c2_write = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    p2_resp = 1'b1; p2_rdata = {8{16'h5A5A}};
    @(posedge clk); #1;
    p2_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({r2_resp, p2_read, p2_write} !== 4'b0000 || r2_rdata !== last_rd) begin
        errors++; $display("FAIL spurious_resp cycle %0d got resp=%b rd=%b wr=%b rdata=%h", i, r2_resp, p2_read, p2_write, r2_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_three_ports();
    int cyc; bit to;
    int order[3] = '{2, 0, 1};
    logic [15:0] ea;
    // Client 1 first, leaving the pointer at 2
    c3_addr[31:16] = 16'h0100; c3_read = 3'b010;
    serve3(1, {4{32'h11111111}}, cyc, to);
    checks++;
    if (to || r3_resp !== 3'b010 || r3_rdata !== {4{32'h11111111}}) begin
      errors++; $display("FAIL p3_first got resp=%b rdata=%h expected 010", r3_resp, r3_rdata);
    end
    c3_read = 3'b000;
    @(posedge clk); #1;
    c3_addr = {16'h1200, 16'h1100, 16'h1000}; c3_read = 3'b111;
    @(posedge clk); #1;
    checks++;
    if (p3_read !== 1'b1 || p3_addr !== 16'h1200) begin
      errors++; $display("FAIL p3_grant2 got rd=%b addr=%h expected 1/1200", p3_read, p3_addr);
    end
    c3_addr[15:0] = 16'h1F00;
    @(posedge clk); #1;
    checks++;
    if (p3_addr !== 16'h1200) begin
      errors++; $display("FAIL p3_addr_frozen got %h expected 1200", p3_addr);
    end
    for (int t = 0; t < 3; t++) begin
      ea = (order[t] == 0) ? 16'h1F00 : (order[t] == 1) ? 16'h1100 : 16'h1200;
      serve3(1, {4{32'h30000000 + 32'(t)}}, cyc, to);
      checks++;
      if (to || r3_resp !== (3'b001 << order[t]) || p3_addr !== ea) begin
        errors++; $display("FAIL p3_order txn %0d got resp=%b addr=%h expected resp=%b addr=%h", t, r3_resp, p3_addr, 3'b001 << order[t], ea);
      end
    end
    c3_read = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    last_rd = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_rw_and_spurious();
    test_three_ports();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-client round-robin arbiter between L1 caches (icache, dcache, and later prefetch/victim clients) and one physical-memory/L2 port.
- Replaces fixed-select muxing with a registered request FSM. It latches the granted client's address and write line, holds the pmem command until pmem_resp, and returns a registered read line plus a one-cycle resp strobe to the granted client only.

Parameters:
- NUM_PORTS, 2, number of client ports (>=2); port 0 has initial priority.
- ADDR_WIDTH, 16, byte address width.
- LINE_WIDTH, 128, cache line width in bits.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cl_read  input  NUM_PORTS  per-client read request, bit i = client i.
- cl_write  input  NUM_PORTS  per-client write request.
- cl_address  input  NUM_PORTS*ADDR_WIDTH  flattened, client i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- cl_wdata  input  NUM_PORTS*LINE_WIDTH  flattened write lines, same packing.
- cl_resp  output  NUM_PORTS  one-hot one-cycle completion strobe.
- cl_rdata  output  LINE_WIDTH  registered read line, shared by all clients, valid when cl_resp[i]=1.
- pmem_read  output  1  memory read command.
- pmem_write  output  1  memory write command.
- pmem_address  output  ADDR_WIDTH  latched address.
- pmem_wdata  output  LINE_WIDTH  latched write line.
- pmem_resp  input  1  memory completion, one cycle.
- pmem_rdata  input  LINE_WIDTH  memory read line, valid with pmem_resp.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0 (cl_resp, cl_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata); priority pointer=0.
- Reset mid-transaction: the transaction is dropped and no cl_resp is issued. A pmem_resp arriving after reset is ignored in IDLE.
- Client i requests when cl_read[i] | cl_write[i]. If both are set, it is treated as a write.
- Client protocol: the client holds its request and address/wdata stable until it sees cl_resp[i], then deasserts on the following cycle.
- IDLE:
  - Grant the first requester scanning from the pointer upward, mod NUM_PORTS.
  - On grant, register grant index g, pmem_address<=cl_address[g], pmem_wdata<=cl_wdata[g] (write only; otherwise hold), and op type. Go to BUSY.
  - No requests: stay in IDLE.
- BUSY:
  - pmem_read or pmem_write (exactly one) is held high, driven from state, starting the cycle after the grant edge.
  - Address and wdata are frozen; client inputs are ignored.
  - On pmem_resp=1: cl_rdata<=pmem_rdata for reads (held unchanged for writes), deassert pmem_read/pmem_write, go to RESP.
- RESP:
  - cl_resp[g]=1 for exactly this one cycle.
  - Pointer<=(g+1) mod NUM_PORTS. Go to IDLE.
  - No grant is made in RESP, so the completed client's stale request cannot be re-granted.
- Latency: request seen in IDLE at edge k → pmem command high during cycle k+1. pmem_resp at edge m → cl_resp high in cycle m+1. Minimum 3 cycles from request to cl_resp with single-cycle memory.
- Fairness: with all clients continuously requesting, grants rotate 0,1,...,N-1,0. No client waits more than N-1 transactions.
- cl_rdata holds its last value between reads. Clients sample it only with their resp.
- pmem_resp while in IDLE or RESP: ignored.
- Widths: pointer and g are $clog2(NUM_PORTS) bits. Wrap uses explicit compare to NUM_PORTS-1, so non-power-of-2 counts are legal.

Test Plan:
- Reset then idle, NUM_PORTS=2: all outputs 0 for 5 cycles; assert rst_n low mid-BUSY → pmem_read drops the next cycle, no cl_resp, and a later pmem_resp is ignored.
- Single read: client0 read addr 0x1230, memory responds after 4 cycles with line 0xA5..A5 → pmem_read high 4 cycles with pmem_address=0x1230; cl_resp=2'b01 for one cycle with cl_rdata=0xA5..A5.
- Single write: client1 write addr 0x4000, wdata 0xDEADBEEF repeated → pmem_write high, pmem_wdata matches, cl_resp=2'b10 for one cycle, cl_rdata unchanged.
- Simultaneous requests with both clients held on: grant order 0,1,0,1 over 4 transactions; cl_resp never has 2 bits set.
- NUM_PORTS=3, all requesting, pointer starting at 2 after a client-1 grant: order 2,0,1. Address changes on a non-granted port during BUSY do not alter pmem_address.
- Read+write both asserted on client0: issued as pmem_write only. A spurious pmem_resp in IDLE produces no cl_resp.
